// File: rtl/redmule_mx_block_encoder.sv
// redmule_mx_block_encoder
//   Collects one MX block of NUM_ELEMS FP16 elements from the RedMulE output
//   stream, derives the shared E8M0 scale and quantises each element to FP8
//   (E4M3 or E5M2, chosen per block). A block may be closed early with
//   fp16_last_i; slots that were never written encode as zero.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   fmt_i                  0 = E4M3, 1 = E5M2 (taken from the first beat)
//   fp16_valid_i/ready_o   input beat handshake
//   fp16_data_i            NUM_LANES FP16 lanes, lane l at [BITW*l +: BITW]
//   fp16_last_i            close the block on this beat
//   mx_val_valid_o/ready_i packed FP8 values handshake
//   mx_val_data_o          element i at [8*i +: 8]
//   mx_exp_valid_o/ready_i shared exponent handshake
//   mx_exp_data_o          E8M0 shared exponent
//   busy_o                 block in flight
module redmule_mx_block_encoder #(
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned BITW      = 16,
    parameter int unsigned NUM_LANES = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      fmt_i,
    input  logic                      fp16_valid_i,
    output logic                      fp16_ready_o,
    input  logic [NUM_LANES*BITW-1:0] fp16_data_i,
    input  logic                      fp16_last_i,
    output logic                      mx_val_valid_o,
    input  logic                      mx_val_ready_i,
    output logic [DATA_W-1:0]         mx_val_data_o,
    output logic                      mx_exp_valid_o,
    input  logic                      mx_exp_ready_i,
    output logic [7:0]                mx_exp_data_o,
    output logic                      busy_o
);

    localparam int unsigned NUM_ELEMS = DATA_W / 8;
    localparam int unsigned BEATS     = NUM_ELEMS / NUM_LANES;
    localparam int unsigned CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    if ((NUM_ELEMS % NUM_LANES) != 0) begin : g_bad_lanes
        $error("NUM_ELEMS must be a multiple of NUM_LANES");
    end
    if (BITW != 16) begin : g_bad_bitw
        $error("only FP16 input elements are supported");
    end

    typedef enum logic [1:0] {
        S_FILL,
        S_ENCODE,
        S_OUT
    } state_e;

    state_e                      r_state, w_state_nxt;
    logic [CNT_W-1:0]            r_cnt;
    logic                        r_fmt;
    logic signed [7:0]           r_max_exp;
    logic                        r_any_nz;
    logic                        r_nan;
    logic [NUM_LANES*BITW-1:0]   r_beats [BEATS];
    logic [NUM_LANES*8-1:0]      r_out   [BEATS];
    logic                        r_val_valid;
    logic                        r_exp_valid;
    logic [7:0]                  r_exp_data;

    logic                        w_fill_hs, w_first, w_close;
    logic                        w_val_hs, w_exp_hs, w_val_left, w_exp_left, w_out_done;
    logic signed [7:0]           w_beat_max, w_new_max, w_x;
    logic                        w_beat_any, w_beat_nan;
    logic [7:0]                  w_shared;
    logic [NUM_LANES*8-1:0]      w_enc_beat;

    // Unbiased exponent used for the block maximum; subnormals count as -14.
    function automatic logic signed [7:0] f_exp_of(input logic [15:0] h);
        return (h[14:10] == 5'd0) ? -8'sd14 : ($signed({3'b000, h[14:10]}) - 8'sd15);
    endfunction

    // Scale h by 2^-x and round-to-nearest-even into E4M3/E5M2, saturating.
    // The input is normalised first so subnormal FP16 values always take a
    // right shift of at least 7; the code is then ((eu-emin) << mb) + q in the
    // normal range (mantissa carry ripples into the exponent) or q below it.
    function automatic logic [7:0] f_quant(input logic [15:0] h,
                                           input logic signed [7:0] x,
                                           input logic fmt);
        logic              sgn;
        logic [4:0]        e;
        logic [9:0]        m;
        logic [3:0]        p;
        logic [10:0]       mn;
        logic signed [7:0] eu, emin, mb, shs, d;
        logic [4:0]        sh;
        logic [15:0]       mn16, q16, gsh, rmask;
        logic              g, st;
        logic [4:0]        qr;
        logic [9:0]        code, cmax;
        sgn  = h[15];
        e    = h[14:10];
        m    = h[9:0];
        emin = fmt ? -8'sd14 : -8'sd6;
        mb   = fmt ? 8'sd2 : 8'sd3;
        cmax = fmt ? 10'h07B : 10'h07E;
        if (e == 5'd0) begin
            p = '0;
            for (int unsigned i = 0; i < 10; i++) begin
                if (m[i]) p = 4'(i);
            end
            eu = $signed({4'b0000, p}) - 8'sd24;
            mn = {1'b0, m} << (4'd10 - p);
        end else begin
            eu = $signed({3'b000, e}) - 8'sd15;
            mn = {1'b1, m};
        end
        eu    = eu - x;
        shs   = ((eu < emin) ? emin : eu) - eu + 8'sd10 - mb;
        sh    = (shs > 8'sd15) ? 5'd15 : shs[4:0];
        mn16  = {5'b00000, mn};
        q16   = mn16 >> sh;
        gsh   = mn16 >> (sh - 5'd1);
        g     = gsh[0];
        rmask = (16'd1 << (sh - 5'd1)) - 16'd1;
        st    = |(mn16 & rmask);
        qr    = q16[4:0] + {4'b0000, g & (st | q16[0])};
        if (eu < emin) begin
            code = {5'b00000, qr};
        end else begin
            d    = eu - emin;
            code = ({4'b0000, d[5:0]} << mb[1:0]) + {5'b00000, qr};
        end
        if (code > cmax) code = cmax;
        if ((e == 5'd0) && (m == 10'd0)) code = '0;
        return {sgn, code[6:0]};
    endfunction

    // Beat statistics; -14 is the floor so max() works without a valid flag.
    always_comb begin
        w_beat_max = -8'sd14;
        w_beat_any = 1'b0;
        w_beat_nan = 1'b0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            if (fp16_data_i[BITW*l+10 +: 5] == 5'h1F) begin
                w_beat_nan = 1'b1;
            end else if (fp16_data_i[BITW*l +: 15] != 15'd0) begin
                w_beat_any = 1'b1;
                if (f_exp_of(fp16_data_i[BITW*l +: BITW]) > w_beat_max)
                    w_beat_max = f_exp_of(fp16_data_i[BITW*l +: BITW]);
            end
        end
    end

    assign w_fill_hs  = (r_state == S_FILL) && fp16_valid_i;
    assign w_first    = (r_cnt == '0);
    assign w_close    = fp16_last_i || (r_cnt == LAST_CNT);
    assign w_new_max  = (w_first || (w_beat_max > r_max_exp)) ? w_beat_max : r_max_exp;

    assign w_val_hs   = r_val_valid && mx_val_ready_i;
    assign w_exp_hs   = r_exp_valid && mx_exp_ready_i;
    assign w_val_left = r_val_valid && !w_val_hs;
    assign w_exp_left = r_exp_valid && !w_exp_hs;
    assign w_out_done = !w_val_left && !w_exp_left;

    assign w_x      = r_max_exp - (r_fmt ? 8'sd15 : 8'sd8);
    assign w_shared = r_nan ? 8'hFF : (!r_any_nz ? 8'h00 : 8'(w_x + 8'sd127));

    always_comb begin
        w_enc_beat = '0;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
            w_enc_beat[8*l +: 8] = r_nan ? 8'h00 : f_quant(r_beats[r_cnt][BITW*l +: BITW], w_x, r_fmt);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_FILL;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        fp16_ready_o = 1'b0;
        unique case (r_state)
            S_FILL: begin
                fp16_ready_o = 1'b1;
                if (fp16_valid_i && w_close) w_state_nxt = S_ENCODE;
            end
            S_ENCODE: begin
                if (r_cnt == LAST_CNT) w_state_nxt = S_OUT;
            end
            S_OUT: begin
                if (w_out_done) w_state_nxt = S_FILL;
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt       <= '0;
            r_fmt       <= 1'b0;
            r_max_exp   <= -8'sd14;
            r_any_nz    <= 1'b0;
            r_nan       <= 1'b0;
            r_beats     <= '{default: '0};
            r_out       <= '{default: '0};
            r_val_valid <= 1'b0;
            r_exp_valid <= 1'b0;
            r_exp_data  <= '0;
        end else begin
            unique case (r_state)
                S_FILL: begin
                    if (w_fill_hs) begin
                        r_beats[r_cnt] <= fp16_data_i;
                        if (w_first) r_fmt <= fmt_i;
                        r_max_exp <= w_new_max;
                        r_any_nz  <= w_beat_any || (!w_first && r_any_nz);
                        r_nan     <= w_beat_nan || (!w_first && r_nan);
                        r_cnt     <= w_close ? '0 : r_cnt + 1'b1;
                    end
                end
                S_ENCODE: begin
                    r_out[r_cnt] <= w_enc_beat;
                    if (r_cnt == LAST_CNT) begin
                        r_cnt       <= '0;
                        r_val_valid <= 1'b1;
                        r_exp_valid <= 1'b1;
                        r_exp_data  <= w_shared;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    if (w_val_hs) r_val_valid <= 1'b0;
                    if (w_exp_hs) r_exp_valid <= 1'b0;
                    // Clearing here makes early-closed blocks see zero slots.
                    if (w_out_done) r_beats <= '{default: '0};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        mx_val_data_o = '0;
        for (int unsigned b = 0; b < BEATS; b++) begin
            mx_val_data_o[b*NUM_LANES*8 +: NUM_LANES*8] = r_out[b];
        end
    end

    assign mx_val_valid_o = r_val_valid;
    assign mx_exp_valid_o = r_exp_valid;
    assign mx_exp_data_o  = r_exp_data;
    assign busy_o         = (r_state != S_FILL) || (r_cnt != '0);

endmodule

// File: tb/tb_redmule_mx_block_encoder.sv
// Directed testbench for redmule_mx_block_encoder (default parameters:
// 32 elements, 8 lanes, 4 beats per block).
module tb_redmule_mx_block_encoder;

    localparam int unsigned DATA_W    = 256;
    localparam int unsigned BITW      = 16;
    localparam int unsigned NUM_LANES = 8;
    localparam int unsigned NUM_ELEMS = DATA_W / 8;
    localparam int unsigned BEATS     = NUM_ELEMS / NUM_LANES;

    logic                      clk = 1'b0;
    logic                      rst_ni;
    logic                      fmt_i;
    logic                      fp16_valid_i;
    logic                      fp16_ready_o;
    logic [NUM_LANES*BITW-1:0] fp16_data_i;
    logic                      fp16_last_i;
    logic                      mx_val_valid_o;
    logic                      mx_val_ready_i;
    logic [DATA_W-1:0]         mx_val_data_o;
    logic                      mx_exp_valid_o;
    logic                      mx_exp_ready_i;
    logic [7:0]                mx_exp_data_o;
    logic                      busy_o;

    always #5 clk = ~clk;

    redmule_mx_block_encoder #(
        .DATA_W    (DATA_W),
        .BITW      (BITW),
        .NUM_LANES (NUM_LANES)
    ) u_dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .fmt_i          (fmt_i),
        .fp16_valid_i   (fp16_valid_i),
        .fp16_ready_o   (fp16_ready_o),
        .fp16_data_i    (fp16_data_i),
        .fp16_last_i    (fp16_last_i),
        .mx_val_valid_o (mx_val_valid_o),
        .mx_val_ready_i (mx_val_ready_i),
        .mx_val_data_o  (mx_val_data_o),
        .mx_exp_valid_o (mx_exp_valid_o),
        .mx_exp_ready_i (mx_exp_ready_i),
        .mx_exp_data_o  (mx_exp_data_o),
        .busy_o         (busy_o)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [15:0] tb_elems [NUM_ELEMS];
    logic [7:0]  tb_bytes [NUM_ELEMS];

    task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                            input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] exp_bus();
        logic [DATA_W-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < NUM_ELEMS; i++) v[8*i +: 8] = tb_bytes[i];
        return v;
    endfunction

    task automatic set_all(input logic [15:0] e, input logic [7:0] b);
        for (int unsigned i = 0; i < NUM_ELEMS; i++) begin
            tb_elems[i] = e;
            tb_bytes[i] = b;
        end
    endtask

    // Feeds nbeats beats; fp16_last_i marks the final beat of a short block.
    // fmt_i is flipped after the first beat to show it is ignored mid-block.
    task automatic send_block(input logic fmt, input int unsigned nbeats);
        fmt_i = fmt;
        for (int unsigned b = 0; b < nbeats; b++) begin
            fp16_valid_i = 1'b1;
            fp16_last_i  = (b == nbeats - 1) && (nbeats < BEATS);
            for (int unsigned l = 0; l < NUM_LANES; l++)
                fp16_data_i[BITW*l +: BITW] = tb_elems[b*NUM_LANES + l];
            check_eq("in_ready", DATA_W'(fp16_ready_o), DATA_W'(1));
            @(posedge clk); #1;
            fmt_i = ~fmt;
        end
        fp16_valid_i = 1'b0;
        fp16_last_i  = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int unsigned exp_lat);
        int unsigned n;
        n = 0;
        while (!(mx_val_valid_o && mx_exp_valid_o) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq({tag, "_latency"}, DATA_W'(n), DATA_W'(exp_lat));
    endtask

    task automatic check_block(input string tag, input logic [7:0] exp_e);
        check_eq({tag, "_exp"}, DATA_W'(mx_exp_data_o), DATA_W'(exp_e));
        check_eq({tag, "_val"}, mx_val_data_o, exp_bus());
    endtask

    task automatic finish_out(input string tag);
        mx_val_ready_i = 1'b1;
        mx_exp_ready_i = 1'b1;
        @(posedge clk); #1;
        mx_val_ready_i = 1'b0;
        mx_exp_ready_i = 1'b0;
        check_eq({tag, "_valids_drop"}, DATA_W'({mx_val_valid_o, mx_exp_valid_o}), DATA_W'(0));
        check_eq({tag, "_ready_back"}, DATA_W'(fp16_ready_o), DATA_W'(1));
    endtask

    task automatic run_block(input string tag, input logic fmt, input int unsigned nbeats,
                             input logic [7:0] exp_e);
        send_block(fmt, nbeats);
        wait_out(tag, BEATS);
        check_block(tag, exp_e);
        finish_out(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni         = 1'b1;
        fmt_i          = 1'b0;
        fp16_valid_i   = 1'b0;
        fp16_data_i    = '0;
        fp16_last_i    = 1'b0;
        mx_val_ready_i = 1'b0;
        mx_exp_ready_i = 1'b0;
        #2 rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", DATA_W'(fp16_ready_o), DATA_W'(1));
        check_eq("rst_val_valid", DATA_W'(mx_val_valid_o), DATA_W'(0));
        check_eq("rst_exp_valid", DATA_W'(mx_exp_valid_o), DATA_W'(0));
        check_eq("rst_val_data", mx_val_data_o, DATA_W'(0));
        check_eq("rst_exp_data", DATA_W'(mx_exp_data_o), DATA_W'(0));
        check_eq("rst_busy", DATA_W'(busy_o), DATA_W'(0));
        @(negedge clk) rst_ni = 1'b1;
        @(posedge clk); #1;

        // 1.0 everywhere: max exp 0 -> X=-8 (E4M3) / -15 (E5M2), both code 0x78
        set_all(16'h3C00, 8'h78);
        run_block("ones_e4m3", 1'b0, BEATS, 8'h77);
        run_block("ones_e5m2", 1'b1, BEATS, 8'h70);

        // 0x5BC0 = 248: X=-1, 496 rounds to 512 -> saturate to 0x7E
        set_all(16'h0000, 8'h00);
        tb_elems[5] = 16'h5BC0;
        tb_bytes[5] = 8'h7E;
        run_block("sat_e4m3", 1'b0, BEATS, 8'h7E);

        // all negative zeros: shared 0, sign-only values
        set_all(16'h8000, 8'h80);
        run_block("negzero", 1'b0, BEATS, 8'h00);

        // NaN in the block forces 0xFF scale and zero values
        set_all(16'h3C00, 8'h00);
        tb_elems[0] = 16'h7E00;
        run_block("nan", 1'b0, BEATS, 8'hFF);

        // early close after two beats: upper half zero, latency still 4
        set_all(16'h3C00, 8'h78);
        for (int unsigned i = 16; i < NUM_ELEMS; i++) tb_bytes[i] = 8'h00;
        run_block("early", 1'b0, 2, 8'h77);

        // E5M2 rounding: subnormal 2^-24 -> 2^-9 (0x18), -1.5 (0xFA),
        // 1.125 tie to even (0x78), 1.375 tie to even (0x7A)
        set_all(16'h3C00, 8'h78);
        tb_elems[1] = 16'h0001; tb_bytes[1] = 8'h18;
        tb_elems[2] = 16'hBE00; tb_bytes[2] = 8'hFA;
        tb_elems[3] = 16'h3C80; tb_bytes[3] = 8'h78;
        tb_elems[4] = 16'h3D80; tb_bytes[4] = 8'h7A;
        run_block("round_e5m2", 1'b1, BEATS, 8'h70);

        // backpressure on the value port only
        set_all(16'h3C00, 8'h78);
        send_block(1'b0, BEATS);
        wait_out("bp", BEATS);
        check_block("bp", 8'h77);
        mx_exp_ready_i = 1'b1;
        mx_val_ready_i = 1'b0;
        @(posedge clk); #1;
        mx_exp_ready_i = 1'b0;
        check_eq("bp_exp_drop", DATA_W'(mx_exp_valid_o), DATA_W'(0));
        check_eq("bp_val_hold", DATA_W'(mx_val_valid_o), DATA_W'(1));
        repeat (4) @(posedge clk);
        #1;
        check_eq("bp_val_stable", mx_val_data_o, exp_bus());
        check_eq("bp_in_blocked", DATA_W'(fp16_ready_o), DATA_W'(0));
        check_eq("bp_val_still", DATA_W'(mx_val_valid_o), DATA_W'(1));
        check_eq("bp_busy", DATA_W'(busy_o), DATA_W'(1));
        mx_val_ready_i = 1'b1;
        @(posedge clk); #1;
        mx_val_ready_i = 1'b0;
        check_eq("bp_val_drop", DATA_W'(mx_val_valid_o), DATA_W'(0));
        check_eq("bp_ready_back", DATA_W'(fp16_ready_o), DATA_W'(1));

        // reset while encoding a NaN block, then a clean short block
        set_all(16'h3C00, 8'h00);
        tb_elems[0] = 16'h7E00;
        send_block(1'b0, BEATS);
        @(posedge clk); #1;
        rst_ni = 1'b0;
        #1;
        check_eq("abort_valids", DATA_W'({mx_val_valid_o, mx_exp_valid_o}), DATA_W'(0));
        check_eq("abort_in_ready", DATA_W'(fp16_ready_o), DATA_W'(1));
        check_eq("abort_val_data", mx_val_data_o, DATA_W'(0));
        check_eq("abort_busy", DATA_W'(busy_o), DATA_W'(0));
        @(negedge clk) rst_ni = 1'b1;
        @(posedge clk); #1;
        set_all(16'h3C00, 8'h00);
        for (int unsigned i = 0; i < NUM_LANES; i++) tb_bytes[i] = 8'h78;
        run_block("post_abort", 1'b1, 1, 8'h70);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
